fifo_8x16_reader: RTL and testbench

Read-side drain controller for `fifo_8x16`. It pops bytes from the FIFO through its `rd_en`/`empty`/`data_out` port and presents them, in order, on a valid/ready output stream. It hides the FIFO's one-cycle read latency behind a 2-entry output buffer, so downstream logic sees a clean handshake that sustains one byte per clock. It sits between `fifo_8x16` and any byte consumer, such as a serializer or packet parser.

---
 rtl/fifo_8x16_reader.sv | 108 ++++++++++
 tb/tb_fifo_8x16_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_8x16_reader.sv
// Drain controller for fifo_8x16: pops bytes and presents them on a valid/ready stream,
// hiding the FIFO's one-cycle read latency behind a 2-entry output buffer.
module fifo_8x16_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  rd_count,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              pop;
    logic [2:0]        pending;

    assign pop     = (occ_q != 2'd0) && m_ready;
    // Slots still claimed after this cycle's pop; a new read needs one free slot.
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign fifo_rd_en = rst && (state_q == RUN) && !fifo_empty && (pending < 3'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = STOP;
            end
            STOP: begin
                if (enable) begin
                    state_d = RUN;
                end else if (!inflight_q && (occ_q == 2'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pop shifts the tail forward first, so a same-cycle capture lands behind the survivor.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (pop) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
        end
        if (inflight_q) begin
            if (occ_d == 2'd0) begin
                head_d = fifo_data;
            end else begin
                tail_d = fifo_data;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    assign inflight_d = fifo_rd_en;
    assign cnt_d      = cnt_q + CNT_W'(pop);
    assign busy_d     = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = head_q;
    assign rd_count = cnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_8x16_reader.sv
// Bench for fifo_8x16_reader: behavioural FIFO plus a scoreboard/rule model of the reader,
// directed scenarios followed by a randomized phase.
module tb_fifo_8x16_reader;

    logic clk = 1'b0;
    logic rst, enable, m_ready, wr_en;
    logic [7:0] wr_data;
    logic fifo_empty, fifo_rd_en, rd_en4;
    logic [7:0] fifo_data, m_data, data4;
    logic m_valid, valid4, busy, busy4;
    logic [15:0] rd_count;
    logic [3:0] count4;

    always #5 clk = ~clk;

    fifo_8x16_reader #(.DATA_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .rd_count(rd_count), .busy(busy)
    );

    fifo_8x16_reader #(.DATA_W(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_en(rd_en4), .fifo_data(fifo_data), .m_valid(valid4),
        .m_ready(m_ready), .m_data(data4), .rd_count(count4), .busy(busy4)
    );

    // Behavioural 16-deep FIFO with registered read data, sharing rst.
    logic [7:0] fmem [16];
    logic [4:0] fcnt;
    logic [3:0] fwp, frp;
    logic f_rd, f_wr;
    assign f_rd = fifo_rd_en && (fcnt != 5'd0);
    assign f_wr = wr_en && (fcnt != 5'd16);
    assign fifo_empty = (fcnt == 5'd0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt <= 5'd0;
            fwp <= 4'd0;
            frp <= 4'd0;
            fifo_data <= 8'd0;
        end else begin
            if (f_rd) begin
                fifo_data <= fmem[frp];
                frp <= frp + 4'd1;
            end
            if (f_wr) begin
                fmem[fwp] <= wr_data;
                fwp <= fwp + 4'd1;
            end
            fcnt <= fcnt + {4'b0, f_wr} - {4'b0, f_rd};
        end
    end

    // Reference model state
    int issued, delivered, last_rd, st;
    logic [31:0] cnt;
    logic [7:0] expq [$];
    bit hold_v;
    logic [7:0] hold_d;

    int ncmp = 0, nerr = 0;
    int t, n_rd, n_pop, first_valid, first_pop, last_pop, first_rd, last_busy_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_track();
        t = 0; n_rd = 0; n_pop = 0;
        first_valid = -1; first_pop = -1; last_pop = -1; first_rd = -1; last_busy_t = -1;
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic step();
        int outst, cap;
        bit valid_exp, pop_m, rd_exp;
        #1;
        outst = issued - delivered;
        cap = outst - last_rd;
        valid_exp = (cap > 0);
        pop_m = valid_exp && (m_ready === 1'b1);
        rd_exp = (rst === 1'b1) && (st == 1) && (fifo_empty === 1'b0) &&
                 ((outst - int'(pop_m)) < 2);

        if (hold_v && rst === 1'b1) begin
            chk("hold_valid", {31'b0, m_valid}, 32'd1);
            chk("hold_data", {24'b0, m_data}, {24'b0, hold_d});
        end
        chk("m_valid", {31'b0, m_valid}, {31'b0, valid_exp});
        chk("m_valid4", {31'b0, valid4}, {31'b0, valid_exp});
        if (valid_exp) begin
            chk("m_data", {24'b0, m_data}, {24'b0, expq[0]});
            chk("m_data4", {24'b0, data4}, {24'b0, expq[0]});
        end else if (rst === 1'b0) begin
            chk("m_data_rst", {24'b0, m_data}, 32'd0);
        end
        chk("rd_en", {31'b0, fifo_rd_en}, {31'b0, rd_exp});
        chk("rd_en4", {31'b0, rd_en4}, {31'b0, rd_exp});
        chk("busy", {31'b0, busy}, {31'b0, st != 0});
        chk("busy4", {31'b0, busy4}, {31'b0, st != 0});
        chk("rd_count", {16'b0, rd_count}, {16'b0, cnt[15:0]});
        chk("rd_count4", {28'b0, count4}, {28'b0, cnt[3:0]});

        if (fifo_rd_en === 1'b1) begin
            n_rd++;
            if (first_rd < 0) first_rd = t;
        end
        if (m_valid === 1'b1 && first_valid < 0) first_valid = t;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            n_pop++;
            if (first_pop < 0) first_pop = t;
            last_pop = t;
        end
        if (busy === 1'b1) last_busy_t = t;

        hold_v = (rst === 1'b1) && (m_valid === 1'b1) && (m_ready === 1'b0);
        hold_d = m_data;

        if (rst === 1'b1) begin
            if (pop_m) begin
                void'(expq.pop_front());
                delivered++;
                cnt++;
            end
            if (f_wr === 1'b1) expq.push_back(wr_data);
            last_rd = (f_rd === 1'b1) ? 1 : 0;
            issued += last_rd;
            case (st)
                0: st = enable ? 1 : 0;
                1: st = enable ? 1 : 2;
                default: st = enable ? 1 : ((outst == 0) ? 0 : 2);
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        issued = 0; delivered = 0; last_rd = 0; st = 0; cnt = 0; hold_v = 0;
        expq.delete();
        chk("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_data", {24'b0, m_data}, 32'd0);
        chk("rst_rd_count", {16'b0, rd_count}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rd_count4", {28'b0, count4}, 32'd0);
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
    endtask

    logic [7:0] basic_bytes [3];

    initial begin
        basic_bytes[0] = 8'hA1;
        basic_bytes[1] = 8'hB2;
        basic_bytes[2] = 8'hC3;
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        clear_track();
        @(negedge clk);

        // Reset held with enable and write attempts active
        enable = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
        apply_reset();
        wr_en = 1'b0; enable = 1'b0;

        // Basic drain
        apply_reset();
        m_ready = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = basic_bytes[i];
            step();
        end
        wr_en = 1'b0;
        clear_track();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("basic_rd_pulses", n_rd, 3);
        chk("basic_first_rd", first_rd, 1);
        chk("basic_first_valid", first_valid, 3);
        chk("basic_first_pop", first_pop, 3);
        chk("basic_last_pop", last_pop, 5);
        chk("basic_count", {16'b0, rd_count}, 32'd3);
        chk("basic_busy", {31'b0, busy}, 32'd1);

        // Backpressure
        enable = 1'b0;
        apply_reset();
        m_ready = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'h10 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        clear_track();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("bp_rd_pulses", n_rd, 2);
        chk("bp_valid", {31'b0, m_valid}, 32'd1);
        chk("bp_data", {24'b0, m_data}, 32'h10);
        m_ready = 1'b1;
        clear_track();
        for (int i = 0; i < 10; i++) step();
        chk("bp_restart_rd", first_rd, 0);
        chk("bp_pops", n_pop, 5);
        chk("bp_first_pop", first_pop, 0);
        chk("bp_last_pop", last_pop, 4);
        chk("bp_count", {16'b0, rd_count}, 32'd5);

        // Full-rate stream of 16 random bytes
        enable = 1'b0;
        apply_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;
        clear_track();
        enable = 1'b1;
        for (int i = 0; i < 24; i++) step();
        chk("full_pops", n_pop, 16);
        chk("full_consecutive", last_pop - first_pop, 15);
        chk("full_rd_pulses", n_rd, 16);
        chk("full_count", {16'b0, rd_count}, 32'd16);
        chk("full_count4", {28'b0, count4}, 32'd0);

        // Enable drop with a read in flight
        enable = 1'b0;
        apply_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) step();
        enable = 1'b0;
        step();
        chk("drop_inflight", last_rd, 1);
        clear_track();
        for (int i = 0; i < 12; i++) step();
        chk("drop_no_rd", n_rd, 0);
        chk("drop_all_delivered", delivered, issued);
        chk("drop_busy_fall", last_busy_t, last_pop + 1);
        chk("drop_busy_end", {31'b0, busy}, 32'd0);
        chk("drop_fifo_left", {27'b0, fcnt}, 8 - issued);

        // Counter wrap on the CNT_W=4 instance
        apply_reset();
        enable = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("wrap_count4", {28'b0, count4}, 32'd1);
        chk("wrap_count16", {16'b0, rd_count}, 32'd17);

        // Randomized traffic
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            wr_en = (fcnt < 5'd14) && ($urandom_range(0, 1) == 1);
            wr_data = 8'($urandom);
            step();
        end

        // Reset asserted mid-stream
        enable = 1'b1;
        m_ready = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'($urandom);
            step();
        end
        chk("pre_rst_valid", {31'b0, m_valid}, 32'd1);
        apply_reset();
        wr_en = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
